// File: rtl/pa_dcache_data_ctrl_if.sv
// D-cache data controller bus bundle: LSU/BIU requests
// plus the data SRAM port.
interface pa_dcache_data_ctrl_if;
  logic        ld_req;
  logic [11:0] ld_idx;
  logic        ld_grant;
  logic        ld_rdata_vld;
  logic [31:0] ld_rdata;
  logic        st_req;
  logic [11:0] st_idx;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        st_grant;
  logic        rf_req;
  logic [9:0]  rf_line;
  logic        rf_ack;
  logic        rf_beat_vld;
  logic [31:0] rf_beat_data;
  logic        rf_done;
  logic        ev_req;
  logic [9:0]  ev_line;
  logic        ev_ack;
  logic        ev_data_vld;
  logic [31:0] ev_data;
  logic        ev_last;
  logic        data_clk_en;
  logic        data_cen;
  logic        data_gwen;
  logic [31:0] data_wen;
  logic [11:0] data_idx;
  logic [31:0] data_din;
  logic [31:0] data_dout;

  modport slave (
    input  ld_req, ld_idx,
    input  st_req, st_idx, st_be, st_wdata,
    input  rf_req, rf_line, rf_beat_vld, rf_beat_data,
    input  ev_req, ev_line,
    input  data_dout,
    output ld_grant, ld_rdata_vld, ld_rdata,
    output st_grant,
    output rf_ack, rf_done,
    output ev_ack, ev_data_vld, ev_data, ev_last,
    output data_clk_en, data_cen, data_gwen,
    output data_wen, data_idx, data_din
  );

  modport master (
    output ld_req, ld_idx,
    output st_req, st_idx, st_be, st_wdata,
    output rf_req, rf_line, rf_beat_vld, rf_beat_data,
    output ev_req, ev_line,
    output data_dout,
    input  ld_grant, ld_rdata_vld, ld_rdata,
    input  st_grant,
    input  rf_ack, rf_done,
    input  ev_ack, ev_data_vld, ev_data, ev_last,
    input  data_clk_en, data_cen, data_gwen,
    input  data_wen, data_idx, data_din
  );
endinterface

// File: rtl/pa_dcache_data_ctrl.sv
// D-cache data SRAM access controller: load/store
// arbitration, 4-beat refill and 4-beat eviction.
module pa_dcache_data_ctrl (
  input logic              forever_cpuclk,
  input logic              cpurst_b,
  pa_dcache_data_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    EVICT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [9:0]  line_q, line_d;
  logic        ld_vld_q, ev_vld_q;
  logic        ev_last_q, rf_done_q;

  logic        idle;
  logic        take_ev, take_rf;
  logic        take_st, take_ld;
  logic        cen, gwen;
  logic [31:0] wen, din;
  logic [11:0] idx;
  logic [31:0] st_wen;

  // Grants are held off while reset is asserted.
  assign idle    = (state_q == IDLE) & cpurst_b;
  assign take_ev = idle & bus.ev_req;
  assign take_rf = idle & ~bus.ev_req & bus.rf_req;
  assign take_st = idle & ~bus.ev_req & ~bus.rf_req
                 & bus.st_req;
  assign take_ld = idle & ~bus.ev_req & ~bus.rf_req
                 & ~bus.st_req & bus.ld_req;

  assign st_wen = {{8{~bus.st_be[3]}},
                   {8{~bus.st_be[2]}},
                   {8{~bus.st_be[1]}},
                   {8{~bus.st_be[0]}}};

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      line_q  <= 10'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          take_ev: begin
            state_d = EVICT;
            cnt_d   = 2'd0;
            line_d  = bus.ev_line;
          end
          take_rf: begin
            state_d = REFILL;
            cnt_d   = 2'd0;
            line_d  = bus.rf_line;
          end
          default: ;
        endcase
      end
      REFILL: begin
        if (bus.rf_beat_vld) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = IDLE;
        end
      end
      EVICT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cen  = 1'b1;
    gwen = 1'b1;
    wen  = '1;
    idx  = '0;
    din  = '0;
    unique case (state_q)
      IDLE: begin
        if (take_st) begin
          cen  = 1'b0;
          gwen = 1'b0;
          wen  = st_wen;
          idx  = bus.st_idx;
          din  = bus.st_wdata;
        end else if (take_ld) begin
          cen = 1'b0;
          idx = bus.ld_idx;
        end
      end
      REFILL: begin
        if (bus.rf_beat_vld) begin
          cen  = 1'b0;
          gwen = 1'b0;
          wen  = '0;
          idx  = {line_q, cnt_q};
          din  = bus.rf_beat_data;
        end
      end
      EVICT: begin
        cen = 1'b0;
        idx = {line_q, cnt_q};
      end
      default: ;
    endcase
  end

  // Read-return pipe runs independently of the FSM.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ld_vld_q  <= 1'b0;
      ev_vld_q  <= 1'b0;
      ev_last_q <= 1'b0;
      rf_done_q <= 1'b0;
    end else begin
      ld_vld_q  <= take_ld;
      ev_vld_q  <= (state_q == EVICT);
      ev_last_q <= (state_q == EVICT) & (cnt_q == 2'd3);
      rf_done_q <= (state_q == REFILL) & bus.rf_beat_vld
                 & (cnt_q == 2'd3);
    end
  end

  assign bus.ld_grant     = take_ld;
  assign bus.st_grant     = take_st;
  assign bus.rf_ack       = take_rf;
  assign bus.ev_ack       = take_ev;
  assign bus.ld_rdata_vld = ld_vld_q;
  assign bus.ld_rdata     = ld_vld_q ? bus.data_dout : '0;
  assign bus.ev_data_vld  = ev_vld_q;
  assign bus.ev_data      = ev_vld_q ? bus.data_dout : '0;
  assign bus.ev_last      = ev_last_q;
  assign bus.rf_done      = rf_done_q;
  assign bus.data_cen     = cen;
  assign bus.data_gwen    = gwen;
  assign bus.data_wen     = wen;
  assign bus.data_idx     = idx;
  assign bus.data_din     = din;
  assign bus.data_clk_en  = ~cen;

endmodule

// File: tb/tb_pa_dcache_data_ctrl.sv
// Directed bench for pa_dcache_data_ctrl with a
// behavioural 1-cycle-latency SRAM.
module tb_pa_dcache_data_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pa_dcache_data_ctrl_if bus ();

  pa_dcache_data_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus)
  );

  logic [31:0] mem [0:4095];
  logic [31:0] dout_q = '0;
  assign bus.data_dout = dout_q;

  // SRAM model: bit-masked write, registered read.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[12'h010] <= 32'hCAFE0010;
      mem[12'h020] <= 32'h11223344;
    end else if (!bus.data_cen) begin
      if (!bus.data_gwen)
        mem[bus.data_idx] <=
          (mem[bus.data_idx] & bus.data_wen) |
          (bus.data_din & ~bus.data_wen);
      else
        dout_q <= mem[bus.data_idx];
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.ld_req = 0; bus.ld_idx = '0;
    bus.st_req = 0; bus.st_idx = '0;
    bus.st_be = '0; bus.st_wdata = '0;
    bus.rf_req = 0; bus.rf_line = '0;
    bus.rf_beat_vld = 0; bus.rf_beat_data = '0;
    bus.ev_req = 0; bus.ev_line = '0;
  endtask

  logic [31:0] dv [4];
  logic [31:0] ev [4];
  logic [31:0] fv [4];

  initial begin
    dv = '{32'hD0D0D0D0, 32'hD1D1D1D1,
           32'hD2D2D2D2, 32'hD3D3D3D3};
    ev = '{32'hE0000000, 32'hE1111111,
           32'hE2222222, 32'hE3333333};
    fv = '{32'hF0F0F0F0, 32'hF1F1F1F1,
           32'hF2F2F2F2, 32'hF3F3F3F3};
    idle_in();
    cyc(); cyc(); #1;
    chk("rst_cen", 32'(bus.data_cen), 32'd1);
    chk("rst_gwen", 32'(bus.data_gwen), 32'd1);
    chk("rst_wen", bus.data_wen, 32'hFFFFFFFF);
    chk("rst_idx", 32'(bus.data_idx), 32'd0);
    chk("rst_din", bus.data_din, 32'd0);
    chk("rst_clken", 32'(bus.data_clk_en), 32'd0);
    chk("rst_vld", {bus.ld_rdata_vld, bus.ev_data_vld,
        bus.ev_last, bus.rf_done}, 32'd0);
    chk("rst_ldata", bus.ld_rdata, 32'd0);
    rst_n = 1;

    // load 0x010
    cyc();
    bus.ld_req = 1; bus.ld_idx = 12'h010; #1;
    chk("ld_grant", 32'(bus.ld_grant), 32'd1);
    chk("ld_cen", 32'(bus.data_cen), 32'd0);
    chk("ld_gwen", 32'(bus.data_gwen), 32'd1);
    chk("ld_idx", 32'(bus.data_idx), 32'h010);
    chk("ld_clken", 32'(bus.data_clk_en), 32'd1);
    cyc(); bus.ld_req = 0; #1;
    chk("ld_vld", 32'(bus.ld_rdata_vld), 32'd1);
    chk("ld_data", bus.ld_rdata, 32'hCAFE0010);

    // byte-masked store then load
    cyc();
    bus.st_req = 1; bus.st_idx = 12'h020;
    bus.st_be = 4'b0101; bus.st_wdata = 32'hAABBCCDD; #1;
    chk("st_grant", 32'(bus.st_grant), 32'd1);
    chk("st_wen", bus.data_wen, 32'hFF00FF00);
    chk("st_gwen", 32'(bus.data_gwen), 32'd0);
    chk("st_din", bus.data_din, 32'hAABBCCDD);
    cyc(); bus.st_req = 0;
    bus.ld_req = 1; bus.ld_idx = 12'h020; #1;
    chk("st_ld_grant", 32'(bus.ld_grant), 32'd1);
    cyc(); bus.ld_req = 0; #1;
    chk("st_ld_data", bus.ld_rdata, 32'h11BB33DD);

    // refill line 5 with a gap, load held throughout
    cyc();
    bus.rf_req = 1; bus.rf_line = 10'h005;
    bus.ld_req = 1; bus.ld_idx = 12'h015; #1;
    chk("rf_ack", 32'(bus.rf_ack), 32'd1);
    chk("rf_ack_ldg", 32'(bus.ld_grant), 32'd0);
    chk("rf_ack_cen", 32'(bus.data_cen), 32'd1);
    for (int b = 0; b < 5; b++) begin
      cyc(); bus.rf_req = 0;
      if (b == 2) begin
        bus.rf_beat_vld = 0; #1;
        chk("rf_gap_cen", 32'(bus.data_cen), 32'd1);
      end else begin
        bus.rf_beat_vld = 1;
        bus.rf_beat_data = dv[b < 2 ? b : b - 1]; #1;
        chk("rf_idx", 32'(bus.data_idx),
            32'h014 + (b < 2 ? b : b - 1));
        chk("rf_wen", bus.data_wen, 32'd0);
        chk("rf_din", bus.data_din, dv[b < 2 ? b : b - 1]);
      end
      chk("rf_ldg_hold", 32'(bus.ld_grant), 32'd0);
      chk("rf_done_early", 32'(bus.rf_done), 32'd0);
    end
    cyc(); bus.rf_beat_vld = 0; #1;
    chk("rf_done", 32'(bus.rf_done), 32'd1);
    chk("rf_ldg", 32'(bus.ld_grant), 32'd1);
    cyc(); bus.ld_req = 0; #1;
    chk("rf_done_once", 32'(bus.rf_done), 32'd0);
    chk("rf_ld_data", bus.ld_rdata, dv[1]);

    // evict line 5
    cyc();
    bus.ev_req = 1; bus.ev_line = 10'h005; #1;
    chk("ev_ack", 32'(bus.ev_ack), 32'd1);
    chk("ev_ack_cen", 32'(bus.data_cen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(); bus.ev_req = 0; #1;
      if (k < 4) begin
        chk("ev_rd_cen", 32'(bus.data_cen), 32'd0);
        chk("ev_rd_idx", 32'(bus.data_idx), 32'h014 + k);
      end else begin
        chk("ev_end_cen", 32'(bus.data_cen), 32'd1);
      end
      chk("ev_vld", 32'(bus.ev_data_vld), k > 0 ? 1 : 0);
      if (k > 0) chk("ev_data", bus.ev_data, dv[k-1]);
      chk("ev_last", 32'(bus.ev_last), k == 4 ? 1 : 0);
    end
    cyc(); #1;
    chk("ev_vld_end", 32'(bus.ev_data_vld), 32'd0);

    // all four requests at once
    cyc();
    bus.ev_req = 1; bus.ev_line = 10'h007;
    bus.rf_req = 1; bus.rf_line = 10'h009;
    bus.st_req = 1; bus.st_idx = 12'h030;
    bus.st_be = 4'hF; bus.st_wdata = 32'h12345678;
    bus.ld_req = 1; bus.ld_idx = 12'h030; #1;
    chk("pri_ev", {bus.ev_ack, bus.rf_ack,
        bus.st_grant, bus.ld_grant}, 32'b1000);
    for (int k = 0; k < 4; k++) begin
      cyc(); bus.ev_req = 0; #1;
      chk("pri_evict", {bus.ev_ack, bus.rf_ack,
          bus.st_grant, bus.ld_grant}, 32'b0000);
    end
    cyc(); #1;
    chk("pri_rf", {bus.ev_ack, bus.rf_ack,
        bus.st_grant, bus.ld_grant}, 32'b0100);
    for (int b = 0; b < 4; b++) begin
      cyc(); bus.rf_req = 0;
      bus.rf_beat_vld = 1; bus.rf_beat_data = ev[b]; #1;
      chk("pri_rf_idx", 32'(bus.data_idx), 32'h024 + b);
      chk("pri_refill", {bus.ev_ack, bus.rf_ack,
          bus.st_grant, bus.ld_grant}, 32'b0000);
    end
    cyc(); bus.rf_beat_vld = 0; #1;
    chk("pri_st", {bus.ev_ack, bus.rf_ack,
        bus.st_grant, bus.ld_grant}, 32'b0010);
    chk("pri_rf_done", 32'(bus.rf_done), 32'd1);
    cyc(); bus.st_req = 0; #1;
    chk("pri_ld", {bus.ev_ack, bus.rf_ack,
        bus.st_grant, bus.ld_grant}, 32'b0001);
    chk("pri_ld_idx", 32'(bus.data_idx), 32'h030);
    cyc(); bus.ld_req = 0; #1;
    chk("pri_ld_data", bus.ld_rdata, 32'h12345678);

    // reset in the middle of a refill
    cyc();
    bus.rf_req = 1; bus.rf_line = 10'h00A; #1;
    chk("rr_ack", 32'(bus.rf_ack), 32'd1);
    for (int b = 0; b < 3; b++) begin
      cyc(); bus.rf_req = 0;
      bus.rf_beat_vld = 1; bus.rf_beat_data = fv[b];
    end
    cyc(); rst_n = 0; bus.rf_beat_vld = 0; #1;
    chk("rr_cen", 32'(bus.data_cen), 32'd1);
    chk("rr_idx", 32'(bus.data_idx), 32'd0);
    chk("rr_wen", bus.data_wen, 32'hFFFFFFFF);
    cyc(); #1;
    chk("rr_no_done", 32'(bus.rf_done), 32'd0);
    rst_n = 1;
    cyc(); #1;
    chk("rr_no_done2", 32'(bus.rf_done), 32'd0);
    cyc();
    bus.rf_req = 1; bus.rf_line = 10'h00A; #1;
    chk("rr_ack2", 32'(bus.rf_ack), 32'd1);
    for (int b = 0; b < 4; b++) begin
      cyc(); bus.rf_req = 0;
      bus.rf_beat_vld = 1; bus.rf_beat_data = fv[b]; #1;
      chk("rr_idx2", 32'(bus.data_idx), 32'h028 + b);
    end
    cyc(); bus.rf_beat_vld = 0; #1;
    chk("rr_done", 32'(bus.rf_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pa_dcache_data_ctrl.md
# pa_dcache_data_ctrl

Access controller and sole initiator of the D-cache data SRAM port. It arbitrates single-word load reads, byte-masked store writes, 4-beat line refills and 4-beat dirty-line eviction reads, and drives the SRAM controls from one clock. It also returns read data with the fixed 1-cycle SRAM latency. It sits between the LSU pipeline / bus interface unit and the data array wrapper.

## Interface
- No parameters. Data word 32 bits; index 12 bits = {line[9:0], word[1:0]}; line = 4 words.
- forever_cpuclk  in  1  sole clock, rising edge
- cpurst_b  in  1  asynchronous active-low reset
- ld_req / ld_idx  in  1 / 12  load read request and word index
- ld_grant  out  1  load accepted this cycle
- ld_rdata_vld / ld_rdata  out  1 / 32  load data, 1 cycle after grant
- st_req / st_idx / st_be / st_wdata  in  1 / 12 / 4 / 32  store request, index, byte enables, data
- st_grant  out  1  store written this cycle
- rf_req / rf_line  in  1 / 10  refill request, held until ack; line index
- rf_ack  out  1  refill accepted (pulse)
- rf_beat_vld / rf_beat_data  in  1 / 32  refill beat, word order 0..3
- rf_done  out  1  pulse, cycle after 4th beat written
- ev_req / ev_line  in  1 / 10  eviction read request, held until ack
- ev_ack  out  1  eviction accepted (pulse)
- ev_data_vld / ev_data / ev_last  out  1 / 32 / 1  evicted words, ev_last on word 3
- data_clk_en, data_cen, data_gwen  out  1  SRAM clock enable, chip enable (low active), global write enable (low active)
- data_wen  out  32  per-bit write enable, low active
- data_idx / data_din  out  12 / 32  SRAM index and write data
- data_dout  in  32  SRAM read data, valid 1 cycle after read

## Operation
- States: IDLE, REFILL, EVICT; 2-bit word counter cnt.
- IDLE priority: ev_req > rf_req > st_req > ld_req. Only one accepted per cycle.
- ev_req in IDLE: ev_ack=1, no SRAM access that cycle, capture ev_line, cnt=0, -> EVICT.
- rf_req in IDLE (no ev_req): rf_ack=1, no SRAM access that cycle, capture rf_line, cnt=0, -> REFILL.
- st_req in IDLE, no line request: st_grant=1; cen=0, gwen=0, idx=st_idx, din=st_wdata, wen byte i = {8{~st_be[i]}}.
- ld_req in IDLE, nothing higher: ld_grant=1; cen=0, gwen=1, idx=ld_idx.
- REFILL: each cycle with rf_beat_vld: cen=0, gwen=0, wen=0, idx={line,cnt}, din=rf_beat_data, cnt++.
  - Beat with cnt==3: -> IDLE; rf_done=1 next cycle.
  - Cycles without rf_beat_vld: idle SRAM, hold state.
- EVICT: read {line,cnt} every cycle, cnt++. After cnt==3 issued -> IDLE.
  - ev_data_vld=1 one cycle after each read; ev_data=data_dout; ev_last with word 3.
- ld/st grants are 0 in REFILL and EVICT and in any IDLE cycle taken by ev/rf ack.
- No SRAM access: cen=1, gwen=1, wen=all 1, idx=0, din=0.
- data_clk_en = ~data_cen.
- Requesters hold req until grant/ack. Index bits above line:word are passed unchanged.

## Timing
- Reset values: state IDLE, cnt 0, data_cen 1, data_gwen 1, data_wen 32'hFFFFFFFF, data_idx 0, data_din 0, data_clk_en 0.
- Reset values of the remaining outputs: all grants, acks, valids, rf_done and ev_last 0; ld_rdata and ev_data 0.
- SRAM controls are combinational from registered state and inputs, sampled by the SRAM at the next edge.
- ld_rdata_vld is a registered copy of ld_grant; ld_rdata = data_dout while valid, else 0.
- ev_data_vld/ev_last are registered copies of the issued eviction reads; the last valid falls in the first IDLE cycle. A new grant in that cycle is legal because the read pipe is independent.
- Eviction: ack at T, reads at T+1..T+4, data at T+2..T+5.
- Refill: minimum 4 beat cycles after the ack cycle. rf_done 1 cycle after the last beat.
- Asynchronous reset mid-operation: abort to IDLE, cnt=0; pending valid/done pulses are dropped. The requester re-issues.

## Test plan
- After reset: ld_req with ld_idx=12'h010 -> ld_grant same cycle; data_cen=0, gwen=1; ld_rdata_vld next cycle with the value stored at 0x010.
- st_req with st_idx=12'h020, st_be=4'b0101, st_wdata=32'hAABBCCDD over 0x11223344 -> data_wen=32'hFF00FF00. A later load of 0x020 returns 32'h11BB33DD.
- rf_req with rf_line=10'h005 and beats D0..D3, one idle gap after beat 1 -> writes to idx 0x014..0x017; rf_done pulses once, cycle after D3; ld_req held throughout is granted only after return to IDLE.
- ev_req with ev_line=10'h005 after the refill above -> ev_data D0..D3 on 4 consecutive cycles; ev_last only with D3; ev_ack one cycle before first read.
- ev_req, rf_req, st_req and ld_req all asserted together -> ev_ack first, then rf_ack after eviction, then st_grant, then ld_grant.
- cpurst_b low during REFILL after beat 2 -> outputs return to reset values immediately; no rf_done; next rf_req restarts at word 0.
